// File: rtl/apb_debug_fabric.sv
// apb_debug_fabric: one upstream APB completer fanned out to NUM_TARGETS
// downstream APB targets selected by the PADDR MSBs. Decode errors and
// targets that never answer are terminated with PSLVERR. Error responses
// are counted. A stretched CORE_RESET is generated from RESET_REQUEST.
//
// Handshake: an upstream transfer is a setup cycle (PSEL=1, PENABLE=0)
// followed by one or more access cycles (PSEL=1, PENABLE=1). The transfer
// completes in the access cycle where PREADY=1, and PRDATA/PSLVERR are
// valid only in that cycle. Dropping PSEL during access abandons the
// transfer with no response.
module apb_debug_fabric #(
    parameter int NUM_TARGETS = 2,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 8,
    parameter int SEL_W       = 2,
    parameter int TIMEOUT     = 15,
    parameter int RESET_HOLD  = 4
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    // upstream APB
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic                          PWRITE,
    input  logic [ADDR_W-1:0]             PADDR,
    input  logic [DATA_W-1:0]             PWDATA,
    output logic [DATA_W-1:0]             PRDATA,
    output logic                          PREADY,
    output logic                          PSLVERR,
    // downstream APB
    output logic [NUM_TARGETS-1:0]        T_PSEL,
    output logic                          T_PENABLE,
    output logic                          T_PWRITE,
    output logic [ADDR_W-SEL_W-1:0]       T_PADDR,
    output logic [DATA_W-1:0]             T_PWDATA,
    input  logic [NUM_TARGETS*DATA_W-1:0] T_PRDATA,
    input  logic [NUM_TARGETS-1:0]        T_PREADY,
    // sideband
    input  logic                          RESET_REQUEST,
    output logic                          CORE_RESET,
    output logic                          BUSY,
    output logic [7:0]                    ERR_COUNT
);

    // NUM_TARGETS always fits in SEL_W+1 bits because 2**SEL_W >= NUM_TARGETS.
    localparam logic [SEL_W:0] LP_NUM_T   = (SEL_W + 1)'(NUM_TARGETS);
    localparam logic [7:0]     LP_TIMEOUT = 8'(TIMEOUT);
    localparam logic [7:0]     LP_HOLD    = 8'(RESET_HOLD);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t                  r_state;
    logic [SEL_W-1:0]        r_idx;
    logic                    r_bad;
    logic [7:0]              r_wait;
    logic [7:0]              r_err_count;
    logic                    r_core_reset;
    logic [7:0]              r_hold;

    logic [SEL_W-1:0]        w_idx;
    logic                    w_idx_ok;
    logic                    w_setup;
    logic                    w_access_phase;
    logic                    w_sel_ready;
    logic [DATA_W-1:0]       w_sel_rdata;
    logic [NUM_TARGETS-1:0]  w_idx_hot;
    logic [NUM_TARGETS-1:0]  w_lat_hot;
    logic                    w_timeout;

    // Address decode of the current PADDR (used in the setup cycle).
    assign w_idx    = PADDR[ADDR_W-1 -: SEL_W];
    assign w_idx_ok = ({1'b0, w_idx} < LP_NUM_T);
    assign w_setup  = PSEL & ~PENABLE;

    // An access cycle of the transfer that the FSM has accepted.
    assign w_access_phase = (r_state == ST_ACCESS) & PSEL & PENABLE;

    // One-hot of the live and latched index, and the latched target's response.
    always_comb begin
        w_idx_hot   = '0;
        w_lat_hot   = '0;
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (w_idx == SEL_W'(i)) begin
                w_idx_hot[i] = 1'b1;
            end
            if (r_idx == SEL_W'(i)) begin
                w_lat_hot[i] = 1'b1;
                w_sel_ready  = T_PREADY[i];
                w_sel_rdata  = T_PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    // Wait budget exhausted with the target still not ready; a target that
    // answers in this same cycle wins and completes normally.
    assign w_timeout = w_access_phase & ~r_bad & ~w_sel_ready & (r_wait == LP_TIMEOUT);

    // Upstream response: decode error, normal completion, or timeout error.
    always_comb begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        if (w_access_phase) begin
            if (r_bad) begin
                PREADY  = 1'b1;
                PSLVERR = 1'b1;
            end else if (w_sel_ready) begin
                PREADY = 1'b1;
                PRDATA = w_sel_rdata;
            end else if (w_timeout) begin
                PREADY  = 1'b1;
                PSLVERR = 1'b1;
            end
        end
    end

    // Downstream select: live decode in setup, latched index during access.
    always_comb begin
        T_PSEL = '0;
        if (r_state == ST_IDLE) begin
            if (w_setup && w_idx_ok) begin
                T_PSEL = w_idx_hot;
            end
        end else begin
            if (PSEL && !r_bad && !w_timeout) begin
                T_PSEL = w_lat_hot;
            end
        end
    end

    assign T_PENABLE = (r_state == ST_ACCESS) & PENABLE;
    assign T_PWRITE  = PWRITE;
    assign T_PADDR   = PADDR[ADDR_W-SEL_W-1:0];
    assign T_PWDATA  = PWDATA;
    assign BUSY      = (r_state == ST_ACCESS);
    assign ERR_COUNT = r_err_count;
    assign CORE_RESET = r_core_reset;

    // Transfer FSM: accept a setup cycle, then count waits until completion or abort.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_bad   <= 1'b0;
            r_wait  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_setup) begin
                        r_state <= ST_ACCESS;
                        r_idx   <= w_idx;
                        r_bad   <= ~w_idx_ok;
                        r_wait  <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (!PSEL || PREADY) begin
                        r_state <= ST_IDLE;
                    end else if (PENABLE && !w_sel_ready && !r_bad && (r_wait != 8'hFF)) begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating count of completed error responses.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_err_count <= '0;
        end else if (PREADY && PSLVERR && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    // CORE_RESET follows RESET_REQUEST and is stretched by RESET_HOLD cycles;
    // any request (or PRESET) reloads the hold so a re-pulse restarts it.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_core_reset <= 1'b1;
            r_hold       <= LP_HOLD;
        end else if (RESET_REQUEST) begin
            r_core_reset <= 1'b1;
            r_hold       <= LP_HOLD;
        end else if (r_hold != 8'd0) begin
            r_core_reset <= 1'b1;
            r_hold       <= r_hold - 8'd1;
        end else begin
            r_core_reset <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apb_debug_fabric.sv
// Bench for apb_debug_fabric with three targets. A per-cycle vector table
// covers single transfers, decode error, back-to-back reads and abort; the
// timeout, error saturation, CORE_RESET stretching and mid-transfer reset
// are hand-written sequences.
module tb_apb_debug_fabric;

    logic        PCLK;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [4:0]  PADDR;
    logic [7:0]  PWDATA;
    logic [7:0]  PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [2:0]  T_PSEL;
    logic        T_PENABLE;
    logic        T_PWRITE;
    logic [2:0]  T_PADDR;
    logic [7:0]  T_PWDATA;
    logic [23:0] T_PRDATA;
    logic [2:0]  T_PREADY;
    logic        RESET_REQUEST;
    logic        CORE_RESET;
    logic        BUSY;
    logic [7:0]  ERR_COUNT;

    int n_total = 0;
    int n_pass  = 0;

    apb_debug_fabric #(
        .NUM_TARGETS (3),
        .ADDR_W      (5),
        .DATA_W      (8),
        .SEL_W       (2),
        .TIMEOUT     (15),
        .RESET_HOLD  (4)
    ) dut (
        .PCLK          (PCLK),
        .PRESET        (PRESET),
        .PSEL          (PSEL),
        .PENABLE       (PENABLE),
        .PWRITE        (PWRITE),
        .PADDR         (PADDR),
        .PWDATA        (PWDATA),
        .PRDATA        (PRDATA),
        .PREADY        (PREADY),
        .PSLVERR       (PSLVERR),
        .T_PSEL        (T_PSEL),
        .T_PENABLE     (T_PENABLE),
        .T_PWRITE      (T_PWRITE),
        .T_PADDR       (T_PADDR),
        .T_PWDATA      (T_PWDATA),
        .T_PRDATA      (T_PRDATA),
        .T_PREADY      (T_PREADY),
        .RESET_REQUEST (RESET_REQUEST),
        .CORE_RESET    (CORE_RESET),
        .BUSY          (BUSY),
        .ERR_COUNT     (ERR_COUNT)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25 ...
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [4:0]  paddr;
        logic [7:0]  pwdata;
        logic [2:0]  tpready;
        logic [23:0] tprdata;
        logic [2:0]  e_tpsel;
        logic        e_tpen;
        logic        e_pready;
        logic        e_pslverr;
        logic [7:0]  e_prdata;
        logic        e_busy;
        logic [7:0]  e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic psel, input logic pen, input logic pwr,
                                input logic [4:0] addr, input logic [7:0] wd,
                                input logic [2:0] tpr, input logic [23:0] tprd,
                                input logic [2:0] e_tpsel, input logic e_tpen,
                                input logic e_rdy, input logic e_slv,
                                input logic [7:0] e_prd, input logic e_busy,
                                input logic [7:0] e_err);
        vec_t v;
        v.psel = psel; v.penable = pen; v.pwrite = pwr; v.paddr = addr;
        v.pwdata = wd; v.tpready = tpr; v.tprdata = tprd;
        v.e_tpsel = e_tpsel; v.e_tpen = e_tpen; v.e_pready = e_rdy;
        v.e_pslverr = e_slv; v.e_prdata = e_prd; v.e_busy = e_busy; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full transfer to addr. T_PREADY for the target rises in access cycle
    // number ready_at (0-based; -1 = never). Bounded at 40 access cycles.
    task automatic do_access(input logic [4:0] addr, input int ready_at,
                             output logic got, output int waits,
                             output logic err, output logic [7:0] data,
                             output logic [2:0] tpsel_resp, output logic [2:0] tpsel_wait);
        logic [2:0] hot;
        logic [1:0] idx;
        idx        = addr[4:3];
        hot        = 3'b001 << idx;
        got        = 1'b0;
        waits      = 0;
        err        = 1'b0;
        data       = '0;
        tpsel_resp = '0;
        tpsel_wait = '0;
        PSEL     = 1'b1;
        PENABLE  = 1'b0;
        PWRITE   = 1'b0;
        PADDR    = addr;
        T_PREADY = '0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        for (int c = 0; c < 40 && !got; c++) begin
            T_PREADY = (c == ready_at) ? hot : 3'b000;
            #4;
            if (PREADY) begin
                got        = 1'b1;
                err        = PSLVERR;
                data       = PRDATA;
                tpsel_resp = T_PSEL;
            end else begin
                waits++;
                tpsel_wait = T_PSEL;
            end
            @(posedge PCLK); #1;
        end
        PSEL     = 1'b0;
        PENABLE  = 1'b0;
        T_PREADY = '0;
    endtask

    logic pat1 [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic exp1 [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic pat2 [11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic exp2 [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        logic       got;
        int         waits;
        logic       err;
        logic [7:0] data;
        logic [2:0] tps_r;
        logic [2:0] tps_w;
        int         bad;

        // clock/reset block
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; T_PRDATA = '0; T_PREADY = '0; RESET_REQUEST = 1'b0;
        repeat (2) @(posedge PCLK);
        #5;
        check("rst_pready",     PREADY,     1'b0);
        check("rst_pslverr",    PSLVERR,    1'b0);
        check("rst_prdata",     PRDATA,     8'h00);
        check("rst_tpsel",      T_PSEL,     3'b000);
        check("rst_tpenable",   T_PENABLE,  1'b0);
        check("rst_busy",       BUSY,       1'b0);
        check("rst_err_count",  ERR_COUNT,  8'd0);
        check("rst_core_reset", CORE_RESET, 1'b1);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        repeat (6) @(posedge PCLK);
        #1;

        // psel pen pwr addr wdata tpr tprdata | tpsel ten rdy slv prdata busy err
        vecs.push_back(mk(1, 0, 0, 5'h0A, 8'h00, 3'b000, 24'h33A511, 3'b010, 0, 0, 0, 8'h00, 0, 8'd0));
        vecs.push_back(mk(1, 1, 0, 5'h0A, 8'h00, 3'b000, 24'h33A511, 3'b010, 1, 0, 0, 8'h00, 1, 8'd0));
        vecs.push_back(mk(1, 1, 0, 5'h0A, 8'h00, 3'b000, 24'h33A511, 3'b010, 1, 0, 0, 8'h00, 1, 8'd0));
        vecs.push_back(mk(1, 1, 0, 5'h0A, 8'h00, 3'b010, 24'h33A511, 3'b010, 1, 1, 0, 8'hA5, 1, 8'd0));
        vecs.push_back(mk(0, 0, 0, 5'h00, 8'h00, 3'b000, 24'h33A511, 3'b000, 0, 0, 0, 8'h00, 0, 8'd0));
        vecs.push_back(mk(1, 0, 1, 5'h18, 8'h5A, 3'b000, 24'h33A511, 3'b000, 0, 0, 0, 8'h00, 0, 8'd0));
        vecs.push_back(mk(1, 1, 1, 5'h18, 8'h5A, 3'b111, 24'h33A511, 3'b000, 1, 1, 1, 8'h00, 1, 8'd0));
        vecs.push_back(mk(0, 0, 0, 5'h00, 8'h00, 3'b000, 24'h33A511, 3'b000, 0, 0, 0, 8'h00, 0, 8'd1));
        vecs.push_back(mk(1, 0, 0, 5'h05, 8'h00, 3'b000, 24'hC3773C, 3'b001, 0, 0, 0, 8'h00, 0, 8'd1));
        vecs.push_back(mk(1, 1, 0, 5'h05, 8'h00, 3'b001, 24'hC3773C, 3'b001, 1, 1, 0, 8'h3C, 1, 8'd1));
        vecs.push_back(mk(1, 0, 0, 5'h16, 8'h00, 3'b000, 24'hC3773C, 3'b100, 0, 0, 0, 8'h00, 0, 8'd1));
        vecs.push_back(mk(1, 1, 0, 5'h16, 8'h00, 3'b100, 24'hC3773C, 3'b100, 1, 1, 0, 8'hC3, 1, 8'd1));
        vecs.push_back(mk(0, 0, 0, 5'h00, 8'h00, 3'b000, 24'hC3773C, 3'b000, 0, 0, 0, 8'h00, 0, 8'd1));
        vecs.push_back(mk(1, 0, 1, 5'h08, 8'h96, 3'b000, 24'hC3773C, 3'b010, 0, 0, 0, 8'h00, 0, 8'd1));
        vecs.push_back(mk(1, 1, 1, 5'h08, 8'h96, 3'b000, 24'hC3773C, 3'b010, 1, 0, 0, 8'h00, 1, 8'd1));
        vecs.push_back(mk(0, 0, 1, 5'h08, 8'h96, 3'b000, 24'hC3773C, 3'b000, 0, 0, 0, 8'h00, 1, 8'd1));
        vecs.push_back(mk(0, 0, 0, 5'h00, 8'h00, 3'b000, 24'hC3773C, 3'b000, 0, 0, 0, 8'h00, 0, 8'd1));

        foreach (vecs[k]) begin
            PSEL     = vecs[k].psel;
            PENABLE  = vecs[k].penable;
            PWRITE   = vecs[k].pwrite;
            PADDR    = vecs[k].paddr;
            PWDATA   = vecs[k].pwdata;
            T_PREADY = vecs[k].tpready;
            T_PRDATA = vecs[k].tprdata;
            #4;
            check($sformatf("v%0d_tpsel", k),    T_PSEL,    vecs[k].e_tpsel);
            check($sformatf("v%0d_tpenable", k), T_PENABLE, vecs[k].e_tpen);
            check($sformatf("v%0d_pready", k),   PREADY,    vecs[k].e_pready);
            check($sformatf("v%0d_pslverr", k),  PSLVERR,   vecs[k].e_pslverr);
            check($sformatf("v%0d_prdata", k),   PRDATA,    vecs[k].e_prdata);
            check($sformatf("v%0d_busy", k),     BUSY,      vecs[k].e_busy);
            check($sformatf("v%0d_err_count", k), ERR_COUNT, vecs[k].e_err);
            check($sformatf("v%0d_tpaddr", k),   T_PADDR,   vecs[k].paddr[2:0]);
            check($sformatf("v%0d_tpwrite", k),  T_PWRITE,  vecs[k].pwrite);
            check($sformatf("v%0d_tpwdata", k),  T_PWDATA,  vecs[k].pwdata);
            @(posedge PCLK); #1;
        end
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;

        // target answers in the same cycle the wait budget runs out
        T_PRDATA = 24'h33A5E7;
        do_access(5'h00, 15, got, waits, err, data, tps_r, tps_w);
        check("prio_got",   got,   1'b1);
        check("prio_waits", waits, 15);
        check("prio_err",   err,   1'b0);
        check("prio_data",  data,  8'hE7);
        #4;
        check("prio_err_count", ERR_COUNT, 8'd1);
        @(posedge PCLK); #1;

        // target 0 never ready
        do_access(5'h00, -1, got, waits, err, data, tps_r, tps_w);
        check("to_got",        got,   1'b1);
        check("to_waits",      waits, 15);
        check("to_err",        err,   1'b1);
        check("to_data",       data,  8'h00);
        check("to_tpsel_resp", tps_r, 3'b000);
        check("to_tpsel_wait", tps_w, 3'b001);
        #4;
        check("to_err_count", ERR_COUNT, 8'd2);
        @(posedge PCLK); #1;
        bad = 0;
        for (int r = 1; r < 300; r++) begin
            do_access(5'h00, -1, got, waits, err, data, tps_r, tps_w);
            if (!(got && waits == 15 && err)) bad++;
        end
        check("to_repeat_bad", bad, 0);
        #4;
        check("to_err_saturated", ERR_COUNT, 8'd255);
        @(posedge PCLK); #1;

        // CORE_RESET stretching and re-pulse restart
        check("core_idle", CORE_RESET, 1'b0);
        for (int k = 0; k < 10; k++) begin
            RESET_REQUEST = pat1[k];
            #4;
            check($sformatf("core_a%0d", k), CORE_RESET, exp1[k]);
            @(posedge PCLK); #1;
        end
        for (int k = 0; k < 11; k++) begin
            RESET_REQUEST = pat2[k];
            #4;
            check($sformatf("core_b%0d", k), CORE_RESET, exp2[k]);
            @(posedge PCLK); #1;
        end
        RESET_REQUEST = 1'b0;

        // PRESET in the 2nd wait cycle of a transfer to target 1
        T_PRDATA = 24'hC3773C;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 5'h09; T_PREADY = '0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #4;
        check("mid_wait1_pready", PREADY, 1'b0);
        check("mid_wait1_busy",   BUSY,   1'b1);
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        #4;
        check("mid_busy",      BUSY,      1'b0);
        check("mid_tpsel",     T_PSEL,    3'b000);
        check("mid_pready",    PREADY,    1'b0);
        check("mid_tpenable",  T_PENABLE, 1'b0);
        check("mid_err_count", ERR_COUNT, 8'd0);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        do_access(5'h16, 0, got, waits, err, data, tps_r, tps_w);
        check("post_got",   got,   1'b1);
        check("post_waits", waits, 0);
        check("post_err",   err,   1'b0);
        check("post_data",  data,  8'hC3);
        check("post_tpsel", tps_r, 3'b100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/apb_debug_fabric.md
APB_DEBUG_FABRIC -- requirements
Module: apb_debug_fabric

Interface
REQ-001 SHALL have parameter NUM_TARGETS, default 2, meaning number of downstream APB targets; legal range 1..8.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning APB address width.
REQ-003 SHALL have parameter DATA_W, default 8, meaning APB data width.
REQ-004 SHALL have parameter SEL_W, default 2, meaning number of PADDR MSBs used as the target index; 2**SEL_W >= NUM_TARGETS.
REQ-005 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of access-phase wait cycles before an error response; legal range 1..255.
REQ-006 SHALL have parameter RESET_HOLD, default 4, meaning the number of cycles CORE_RESET is stretched after RESET_REQUEST falls; legal range 1..255.
REQ-007 SHALL use one clock and a synchronous active-high reset, with ports named as follows.
  - PCLK  in  1  clock
  - PRESET  in  1  synchronous reset, active high
REQ-008 SHALL have the following upstream APB ports.
  - PSEL, PENABLE, PWRITE  in  1 each  APB control
  - PADDR  in  ADDR_W  address
  - PWDATA  in  DATA_W  write data
  - PRDATA  out  DATA_W  read data
  - PREADY, PSLVERR  out  1 each  APB response
REQ-009 SHALL have the following downstream APB ports.
  - T_PSEL  out  NUM_TARGETS  one-hot select
  - T_PENABLE, T_PWRITE  out  1 each
  - T_PADDR  out  ADDR_W-SEL_W  local address, equal to the PADDR LSBs
  - T_PWDATA  out  DATA_W
  - T_PRDATA  in  NUM_TARGETS*DATA_W  target i occupies bits [i*DATA_W +: DATA_W]
  - T_PREADY  in  NUM_TARGETS
REQ-010 SHALL have the following sideband ports.
  - RESET_REQUEST  in  1
  - CORE_RESET  out  1
  - BUSY  out  1  high when the FSM is not IDLE
  - ERR_COUNT  out  8  saturating count of error responses

Function
REQ-011 SHALL index targets by idx = PADDR[ADDR_W-1 -: SEL_W]; idx >= NUM_TARGETS is a decode error.
REQ-012 SHALL implement FSM states IDLE and ACCESS.
  - IDLE -> ACCESS on PSEL=1 with PENABLE=0; the FSM latches idx and the error flag in that cycle.
  - ACCESS -> IDLE when PREADY=1 is driven, or when PSEL=0 (abort; no response and no ERR_COUNT change).
REQ-013 SHALL drive T_PSEL[idx] combinationally during the setup cycle, and T_PSEL[latched idx] with T_PENABLE=PENABLE during ACCESS; all T_PSEL bits SHALL be 0 for an invalid idx.
REQ-014 SHALL pass T_PWRITE, T_PADDR and T_PWDATA through combinationally from the upstream signals.
REQ-015 SHALL, in ACCESS with PENABLE=1 and a valid target, drive PREADY=T_PREADY[idx], PRDATA=T_PRDATA slice when ready (0 otherwise), and PSLVERR=0.
REQ-016 SHALL, in ACCESS with PENABLE=1 and an invalid idx, drive PREADY=1, PSLVERR=1 and PRDATA=0 on the first access cycle (zero wait states).
REQ-017 SHALL keep an access wait counter.
  - The counter clears on entry to ACCESS and increments on each access cycle with T_PREADY low.
  - When the counter equals TIMEOUT and T_PREADY is still low, the block SHALL drive PREADY=1, PSLVERR=1, PRDATA=0 and T_PSEL=0 in that cycle.
  - A target ready in that same cycle SHALL take priority: normal response, no error.
REQ-018 SHALL drive PREADY=0, PSLVERR=0 and PRDATA=0 outside the cases in REQ-015 to REQ-017.
REQ-019 SHALL support back-to-back transfers: a setup cycle directly after a completing cycle is accepted from IDLE without bubbles.
REQ-020 SHALL increment ERR_COUNT by 1 on every cycle with PREADY=1 and PSLVERR=1, saturating at 255.
REQ-021 SHALL register CORE_RESET.
  - CORE_RESET is 1 while RESET_REQUEST=1.
  - CORE_RESET stays 1 for exactly RESET_HOLD cycles after the first cycle RESET_REQUEST is sampled 0.
  - A re-assertion during the hold SHALL restart the hold.
REQ-022 SHALL never let CORE_RESET glitch, because CORE_RESET is driven only from flops.

Reset
REQ-023 SHALL, with PRESET=1 at a PCLK edge, reset the block as follows.
  - FSM=IDLE; wait counter=0; ERR_COUNT=0.
  - CORE_RESET=1, with the hold counter loaded to RESET_HOLD.
  - Outputs: PREADY=0, PSLVERR=0, PRDATA=0, T_PSEL=0, T_PENABLE=0, BUSY=0.
REQ-024 SHALL abandon any transfer in flight when PRESET asserts mid-transfer; no response is returned for that transfer.

Verification
REQ-025 Setup NUM_TARGETS=3, defaults otherwise. Read at PADDR=5'b01_010 with target 1 returning ready after 2 waits and data 8'hA5 -> T_PSEL=3'b010, T_PADDR=3'b010, PREADY high on the 3rd access cycle, PRDATA=8'hA5, PSLVERR=0.
REQ-026 Write to PADDR=5'b11_000 (idx 3, invalid) -> T_PSEL=0 throughout; first access cycle has PREADY=1, PSLVERR=1; ERR_COUNT=1.
REQ-027 Target 0 never ready -> PREADY=1, PSLVERR=1 after exactly 15 wait cycles; T_PSEL drops that cycle. Repeated 300 times -> ERR_COUNT saturates at 255.
REQ-028 Two back-to-back zero-wait reads to targets 0 then 2 -> 4 cycles total, correct data each, BUSY high only in the access cycles.
REQ-029 RESET_REQUEST high 3 cycles, then low -> CORE_RESET high during the request and for exactly 4 cycles after; re-pulse during the hold -> hold restarts at 4.
REQ-030 PRESET asserted in the 2nd wait cycle -> next edge FSM=IDLE, T_PSEL=0, PREADY=0; a following transfer completes normally.
